// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings for the slave memory
package ahb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_t;
  typedef enum logic [2:0] {SZ_BYTE = 3'b000, SZ_HALF = 3'b001, SZ_WORD = 3'b010} hsize_t;
  typedef enum logic [1:0] {OKAY = 2'b00, ERROR = 2'b01} hresp_t;
endpackage

// File: rtl/ahb_byte_lane_dec.sv
// ahb_byte_lane_dec: little-endian lane strobes and alignment check for one AHB beat
module ahb_byte_lane_dec
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr,
  output logic [3:0] lanes,
  output logic       misaligned
);
  assign lanes = hsize == SZ_BYTE ? 4'b0001 << addr :
                 hsize == SZ_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign misaligned = hsize == SZ_HALF ? addr[0] : hsize == SZ_WORD && addr != 2'b00;
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB subordinate over a word memory with wait states, ERROR responses and RAW forwarding
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        HRESETn,
  input  logic        HSELx,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic        HMASTLOCK,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP
);
  localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] LIMIT = 32'(4 * MEM_DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  state_t state, nxt, start;
  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] off, wmask, rd_word;
  logic [3:0] lanes, lanes_q, cnt;
  logic [AW-1:0] idx, idx_q, rd_idx;
  logic borrow, mis, accept, illegal, wr_q, fwd, unused;
  ahb_byte_lane_dec u_dec (.hsize(HSIZE), .addr(HADDR[1:0]), .lanes(lanes), .misaligned(mis));
  assign {borrow, off} = {1'b0, HADDR} - {1'b0, BASE_ADDR};
  assign idx = off[AW+1:2];
  assign accept = HSELx && HREADY && HTRANS[1];
  assign illegal = HSIZE > SZ_WORD || mis || borrow || off >= LIMIT;
  assign start = !accept ? S_IDLE : illegal ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_DATA;
  assign nxt = state == S_WAIT ? (cnt == 4'(WAIT_STATES - 1) ? S_DATA : S_WAIT) :
               state == S_ERR1 ? S_ERR2 : start;
  assign wmask = {{8{lanes_q[3]}}, {8{lanes_q[2]}}, {8{lanes_q[1]}}, {8{lanes_q[0]}}};
  assign rd_idx = state == S_WAIT ? idx_q : idx;
  // a read accepted while a write to the same word commits sees the new bytes
  assign fwd = state == S_DATA && wr_q && rd_idx == idx_q;
  assign rd_word = fwd ? (mem[rd_idx] & ~wmask) | (HWDATA & wmask) : mem[rd_idx];
  assign unused = ^{HTRANS[0], HBURST, HMASTLOCK, HPROT, off};
  always_ff @(posedge clk or negedge HRESETn)
    if (!HRESETn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      HREADY  <= 1'b1;
      HRESP   <= OKAY;
      HRDATA  <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      lanes_q <= '0;
    end else begin
      state  <= nxt;
      cnt    <= state == S_WAIT ? cnt + 4'd1 : 4'd0;
      HREADY <= !(nxt inside {S_WAIT, S_ERR1});
      HRESP  <= nxt inside {S_ERR1, S_ERR2} ? ERROR : OKAY;
      if (nxt == S_DATA) HRDATA <= rd_word;
      if (accept) begin
        idx_q   <= idx;
        wr_q    <= HWRITE;
        lanes_q <= lanes;
      end
    end
  always_ff @(posedge clk)
    if (state == S_DATA && wr_q)
      for (int i = 0; i < 4; i++)
        if (lanes_q[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: pipelined AHB master with scoreboard against zero-wait and 3-wait slaves
module tb_ahb_slave_mem;
  import ahb_pkg::*;
  localparam int DEPTH = 1024;
  typedef struct { logic [31:0] addr; logic wr; logic [2:0] size; logic [31:0] wdata; logic [1:0] trans; } beat_t;
  typedef struct { logic chk; logic [31:0] data; logic [31:0] mask; logic [1:0] resp; int waits; } exp_t;
  logic clk = 0, HRESETn = 0, hsel = 0, use3 = 0, HWRITE = 0, HMASTLOCK = 0;
  logic [31:0] HADDR = 0, HWDATA = 0;
  logic [1:0] HTRANS = 2'b00;
  logic [2:0] HSIZE = 0, HBURST = 0;
  logic [3:0] HPROT = 0;
  logic [31:0] rdata0, rdata3, hrdata;
  logic rdy0, rdy3, hready;
  logic [1:0] resp0, resp3, hresp;
  int total = 0, bad = 0;
  beat_t q[$];
  exp_t sb[$];
  logic [31:0] model [int];
  always #5 clk = ~clk;
  assign hready = use3 ? rdy3 : rdy0;
  assign hresp  = use3 ? resp3 : resp0;
  assign hrdata = use3 ? rdata3 : rdata0;
  ahb_slave_mem #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .HRESETn(HRESETn), .HSELx(hsel && !use3), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HWDATA(HWDATA), .HRDATA(rdata0), .HREADY(rdy0), .HRESP(resp0));
  ahb_slave_mem #(.MEM_DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk(clk), .HRESETn(HRESETn), .HSELx(hsel && use3), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HWDATA(HWDATA), .HRDATA(rdata3), .HREADY(rdy3), .HRESP(resp3));
  function automatic beat_t mk(input logic [31:0] a, input logic w, input logic [2:0] s,
                               input logic [31:0] d, input logic [1:0] t);
    beat_t b;
    b.addr = a; b.wr = w; b.size = s; b.wdata = d; b.trans = t;
    return b;
  endfunction
  // puts the next queued beat on the address bus and records what its data phase must return
  task automatic drive_next(output logic on, output logic [31:0] wd);
    beat_t b;
    exp_t e;
    logic legal;
    logic [31:0] m, old;
    int key;
    on = q.size() > 0;
    wd = '0;
    hsel = on;
    HTRANS = IDLE;
    if (on) begin
      b = q.pop_front();
      HADDR = b.addr; HWRITE = b.wr; HSIZE = b.size; HTRANS = b.trans; wd = b.wdata;
      m = b.size == 3'd0 ? 32'hFF << (8 * b.addr[1:0]) :
          b.size == 3'd1 ? 32'hFFFF << (8 * b.addr[1:0]) : 32'hFFFF_FFFF;
      legal = b.addr < 32'(4 * DEPTH) && (b.size == 3'd0 || (b.size == 3'd1 && !b.addr[0]) ||
              (b.size == 3'd2 && b.addr[1:0] == 2'b00));
      e.chk = 0; e.data = 0; e.mask = m; e.resp = 2'b00; e.waits = 0;
      if (b.trans[1] && !legal) begin
        e.resp = 2'b01;
        e.waits = 1;
      end else if (b.trans[1]) begin
        key = int'(b.addr >> 2) + (use3 ? 1048576 : 0);
        old = model.exists(key) ? model[key] : 32'h0;
        e.waits = use3 ? 3 : 0;
        if (b.wr) model[key] = (old & ~m) | (b.wdata & m);
        else begin
          e.chk = 1;
          e.data = old;
        end
      end
      sb.push_back(e);
    end
  endtask
  task automatic run(input string tag, output int cyc, output logic [31:0] last);
    logic a_on, d_on, rdy;
    logic [1:0] resp;
    logic [31:0] rd, nwd;
    int waits;
    exp_t e;
    d_on = 0; waits = 0; cyc = 0; last = 'x;
    @(posedge clk); #1;
    drive_next(a_on, nwd);
    while ((a_on || d_on) && cyc < 200) begin
      @(negedge clk);
      rdy = hready; resp = hresp; rd = hrdata; cyc++;
      if (d_on && !rdy) begin
        waits++;
        total++;
        if (resp !== sb[0].resp) begin
          bad++;
          $display("FAIL %s wait_resp: got %b want %b", tag, resp, sb[0].resp);
        end
      end
      @(posedge clk); #1;
      if (rdy) begin
        if (d_on) begin
          e = sb.pop_front();
          total += 2;
          if (resp !== e.resp) begin
            bad++;
            $display("FAIL %s resp: got %b want %b", tag, resp, e.resp);
          end
          if (waits != e.waits) begin
            bad++;
            $display("FAIL %s waits: got %0d want %0d", tag, waits, e.waits);
          end
          if (e.chk) begin
            total++;
            last = rd;
            if ((rd & e.mask) !== (e.data & e.mask)) begin
              bad++;
              $display("FAIL %s rdata: got %h want %h mask %h", tag, rd, e.data, e.mask);
            end
          end
        end
        d_on = a_on; waits = 0; HWDATA = nwd;
        drive_next(a_on, nwd);
      end
    end
    if (cyc >= 200) begin
      bad++;
      $display("FAIL %s timeout: got %0d cycles want <200", tag, cyc);
      q.delete(); sb.delete(); hsel = 0; HTRANS = IDLE;
    end
  endtask
  task automatic test_reset();
    HRESETn = 0;
    repeat (3) @(posedge clk);
    #1;
    total += 2;
    if (rdy0 !== 1'b1 || resp0 !== 2'b00 || rdata0 !== 32'h0) begin
      bad++;
      $display("FAIL reset0: got rdy=%b resp=%b rdata=%h want 1 00 0", rdy0, resp0, rdata0);
    end
    if (rdy3 !== 1'b1 || resp3 !== 2'b00 || rdata3 !== 32'h0) begin
      bad++;
      $display("FAIL reset3: got rdy=%b resp=%b rdata=%h want 1 00 0", rdy3, resp3, rdata3);
    end
    @(negedge clk) HRESETn = 1;
  endtask
  task automatic test_word_rw();
    int cyc;
    logic [31:0] last;
    use3 = 0;
    q.push_back(mk(32'h10, 1, 3'd2, 32'hDEAD_BEEF, NONSEQ));
    q.push_back(mk(32'h10, 0, 3'd2, 32'h0, IDLE));
    q.push_back(mk(32'h10, 0, 3'd2, 32'h0, NONSEQ));
    run("word_rw", cyc, last);
    total++;
    if (last !== 32'hDEAD_BEEF || cyc != 4) begin
      bad++;
      $display("FAIL word_rw: got %h/%0d cycles want deadbeef/4", last, cyc);
    end
  endtask
  task automatic test_byte_lanes();
    int cyc;
    logic [31:0] last;
    use3 = 0;
    q.push_back(mk(32'h20, 1, 3'd2, 32'h0, NONSEQ));
    q.push_back(mk(32'h21, 1, 3'd0, 32'h1111_1111, NONSEQ));
    q.push_back(mk(32'h23, 1, 3'd0, 32'h2222_2222, NONSEQ));
    q.push_back(mk(32'h20, 0, 3'd2, 32'h0, NONSEQ));
    q.push_back(mk(32'h23, 0, 3'd0, 32'h0, NONSEQ));
    q.push_back(mk(32'h22, 0, 3'd1, 32'h0, NONSEQ));
    q.push_back(mk(32'h20, 0, 3'd2, 32'h0, NONSEQ));
    run("byte_lanes", cyc, last);
    total++;
    if (last !== 32'h2200_1100) begin
      bad++;
      $display("FAIL byte_lanes: got %h want 22001100", last);
    end
  endtask
  task automatic test_wait_states();
    int cyc;
    logic [31:0] last, d;
    use3 = 1;
    d = $urandom;
    q.push_back(mk(32'h50, 1, 3'd2, d, NONSEQ));
    q.push_back(mk(32'h50, 0, 3'd2, 32'h0, NONSEQ));
    run("wait_states", cyc, last);
    total++;
    if (last !== d || cyc != 9) begin
      bad++;
      $display("FAIL wait_states: got %h/%0d cycles want %h/9", last, cyc, d);
    end
  endtask
  task automatic test_errors();
    int cyc;
    logic [31:0] last;
    use3 = 0;
    q.push_back(mk(32'h0, 1, 3'd2, 32'h1234_5678, NONSEQ));
    q.push_back(mk(32'h2, 1, 3'd1, 32'hAAAA_AAAA, NONSEQ));
    q.push_back(mk(32'h3, 1, 3'd1, 32'hBBBB_BBBB, NONSEQ));
    q.push_back(mk(32'(4 * DEPTH), 0, 3'd2, 32'h0, NONSEQ));
    q.push_back(mk(32'h0, 0, 3'd3, 32'h0, NONSEQ));
    q.push_back(mk(32'(4 * DEPTH - 4), 1, 3'd2, 32'h0BAD_F00D, NONSEQ));
    q.push_back(mk(32'(4 * DEPTH - 4), 0, 3'd2, 32'h0, NONSEQ));
    q.push_back(mk(32'h0, 0, 3'd2, 32'h0, NONSEQ));
    run("errors", cyc, last);
    total++;
    if (last !== 32'hAAAA_5678 || cyc != 12) begin
      bad++;
      $display("FAIL errors: got %h/%0d cycles want aaaa5678/12", last, cyc);
    end
    use3 = 1;
    q.push_back(mk(32'h52, 0, 3'd2, 32'h0, NONSEQ));
    q.push_back(mk(32'h50, 0, 3'd1, 32'h0, NONSEQ));
    run("errors_ws3", cyc, last);
    total++;
    if (cyc != 7) begin
      bad++;
      $display("FAIL errors_ws3: got %0d cycles want 7", cyc);
    end
  endtask
  task automatic test_burst_busy();
    int cyc;
    logic [31:0] last;
    use3 = 0;
    q.push_back(mk(32'h40, 1, 3'd2, 32'hA0A0_0040, NONSEQ));
    q.push_back(mk(32'h44, 1, 3'd2, 32'hA0A0_0044, SEQ));
    q.push_back(mk(32'h48, 1, 3'd2, 32'h0, BUSY));
    q.push_back(mk(32'h48, 1, 3'd2, 32'hA0A0_0048, SEQ));
    q.push_back(mk(32'h4C, 1, 3'd2, 32'hA0A0_004C, SEQ));
    for (int i = 0; i < 4; i++) q.push_back(mk(32'h40 + 32'(4 * i), 0, 3'd2, 32'h0, i == 0 ? NONSEQ : SEQ));
    run("burst_busy", cyc, last);
    total++;
    if (last !== 32'hA0A0_004C || cyc != 10) begin
      bad++;
      $display("FAIL burst_busy: got %h/%0d cycles want a0a0004c/10", last, cyc);
    end
  endtask
  task automatic test_raw();
    int cyc;
    logic [31:0] last;
    use3 = 0;
    q.push_back(mk(32'h30, 1, 3'd2, 32'hCAFE_F00D, NONSEQ));
    q.push_back(mk(32'h30, 0, 3'd2, 32'h0, NONSEQ));
    q.push_back(mk(32'h31, 1, 3'd0, 32'h7777_7777, NONSEQ));
    q.push_back(mk(32'h30, 0, 3'd2, 32'h0, NONSEQ));
    run("raw", cyc, last);
    total++;
    if (last !== 32'hCAFE_770D) begin
      bad++;
      $display("FAIL raw: got %h want cafe770d", last);
    end
    use3 = 1;
    q.push_back(mk(32'h30, 1, 3'd2, 32'h600D_F00D, NONSEQ));
    q.push_back(mk(32'h30, 0, 3'd2, 32'h0, NONSEQ));
    run("raw_ws3", cyc, last);
    total++;
    if (last !== 32'h600D_F00D) begin
      bad++;
      $display("FAIL raw_ws3: got %h want 600df00d", last);
    end
  endtask
  task automatic test_reset_mid_wait();
    int cyc;
    logic [31:0] last;
    use3 = 1;
    @(posedge clk); #1;
    hsel = 1; HADDR = 32'h30; HWRITE = 0; HSIZE = 3'd2; HTRANS = NONSEQ;
    @(posedge clk); #1;
    hsel = 0; HTRANS = IDLE;
    total++;
    if (hready !== 1'b0) begin
      bad++;
      $display("FAIL mid_wait_enter: got hready=%b want 0", hready);
    end
    #2 HRESETn = 0;
    #1;
    total++;
    if (rdy3 !== 1'b1 || resp3 !== 2'b00 || rdata3 !== 32'h0) begin
      bad++;
      $display("FAIL mid_wait_reset: got rdy=%b resp=%b rdata=%h want 1 00 0", rdy3, resp3, rdata3);
    end
    @(negedge clk) HRESETn = 1;
    q.push_back(mk(32'h30, 0, 3'd2, 32'h0, NONSEQ));
    run("after_reset", cyc, last);
    total++;
    if (last !== 32'h600D_F00D) begin
      bad++;
      $display("FAIL after_reset: got %h want 600df00d", last);
    end
  endtask
  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_wait_states();
    test_errors();
    test_burst_busy();
    test_raw();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
